// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler_if
//  Description : Requester bus and UART transmitter control bus shared by
//                the round-robin UART TX scheduler and its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ack;
  logic [7:0]         tx_data;
  logic               tx_wr;
  logic               tx_en;
  logic [2:0]         baud_select;
  logic               tx_busy;

  // Environment side: byte requesters plus the UART transmitter.
  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ack, tx_data, tx_wr, tx_en, baud_select
  );

  // Scheduler side: grants requesters and drives the transmitter controls.
  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ack, tx_data, tx_wr, tx_en, baud_select
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Round-robin sharing of one UART transmitter among N_REQ byte
//                requesters; one frame at a time, baud held during frames,
//                start timeout detection and an idle gap between frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
  parameter int              N_REQ      = 4,
  parameter int              TO_W       = 20,
  parameter logic [TO_W-1:0] TIMEOUT    = 20'hFFFFF,
  parameter int              GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_cfg_enable,
  input  logic [2:0]         i_cfg_baud,
  output logic [2:0]         o_grant_id,
  output logic               o_frame_done,
  output logic               o_err_timeout,
  uart_tx_scheduler_if.slave bus
);

  localparam int               GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TO_W-1:0]  c_to_last  = TIMEOUT - TO_W'(1);
  localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       c_n_req    = 4'(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             r_state, w_state;
  logic               r_busy_meta, r_busy_s;
  logic [2:0]         r_rr_ptr, w_rr_ptr;
  logic [TO_W-1:0]    r_to_cnt, w_to_cnt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt;
  logic [N_REQ-1:0]   r_ack, w_ack;
  logic [7:0]         r_tx_data, w_tx_data;
  logic               r_tx_wr, w_tx_wr;
  logic               r_tx_en, w_tx_en;
  logic [2:0]         r_baud, w_baud;
  logic [2:0]         r_grant_id, w_grant_id;
  logic               r_frame_done, w_frame_done;
  logic               r_err_timeout, w_err_timeout;

  logic               w_found;
  logic [2:0]         w_gnt;
  logic [3:0]         w_cand;
  logic [N_REQ-1:0]   w_vsh;
  logic [3:0]         w_gnt_p1;
  logic [2:0]         w_next_ptr;
  logic [7:0]         w_gnt_data;
  logic [N_REQ-1:0]   w_gnt_ack;

  // Two-flop synchronizer for the transmitter busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy_meta <= 1'b0;
      r_busy_s    <= 1'b0;
    end else begin
      r_busy_meta <= bus.tx_busy;
      r_busy_s    <= r_busy_meta;
    end
  end

  // Round-robin pick: first valid requester at or after r_rr_ptr (the loop
  // runs from the farthest offset down so the nearest one wins).
  always_comb begin
    w_found = 1'b0;
    w_gnt   = 3'd0;
    w_cand  = 4'd0;
    w_vsh   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_cand = {1'b0, r_rr_ptr} + 4'(i);
      if (w_cand >= c_n_req) begin
        w_cand = w_cand - c_n_req;
      end
      w_vsh = bus.req_valid >> w_cand;
      if (w_vsh[0]) begin
        w_found = 1'b1;
        w_gnt   = w_cand[2:0];
      end
    end
  end

  assign w_gnt_p1   = {1'b0, w_gnt} + 4'd1;
  assign w_next_ptr = (w_gnt_p1 >= c_n_req) ? 3'd0 : w_gnt_p1[2:0];
  assign w_gnt_data = 8'(bus.req_data >> {w_gnt, 3'b000});
  assign w_gnt_ack  = {{(N_REQ-1){1'b0}}, 1'b1} << w_gnt;

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    w_state       = r_state;
    w_rr_ptr      = r_rr_ptr;
    w_to_cnt      = r_to_cnt;
    w_gap_cnt     = r_gap_cnt;
    w_ack         = '0;
    w_tx_data     = r_tx_data;
    w_tx_wr       = r_tx_wr;
    w_tx_en       = r_tx_en;
    w_baud        = r_baud;
    w_grant_id    = r_grant_id;
    w_frame_done  = 1'b0;
    w_err_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Configuration is only allowed to move between frames.
        w_baud  = i_cfg_baud;
        w_tx_en = i_cfg_enable;
        if (i_cfg_enable && w_found) begin
          w_tx_data  = w_gnt_data;
          w_grant_id = w_gnt;
          w_ack      = w_gnt_ack;
          w_tx_wr    = 1'b1;
          w_to_cnt   = '0;
          w_rr_ptr   = w_next_ptr;
          w_state    = S_WRITE;
        end
      end
      S_WRITE: begin
        w_to_cnt = r_to_cnt + TO_W'(1);
        if (r_busy_s) begin
          w_tx_wr = 1'b0;
          w_state = S_BUSY;
        end else if (r_to_cnt == c_to_last) begin
          // Transmitter never started: the byte is dropped, not retried.
          w_tx_wr       = 1'b0;
          w_err_timeout = 1'b1;
          w_gap_cnt     = '0;
          w_state       = S_GAP;
        end
      end
      S_BUSY: begin
        if (!r_busy_s) begin
          w_frame_done = 1'b1;
          w_gap_cnt    = '0;
          w_state      = S_GAP;
        end
      end
      S_GAP: begin
        // Lets the transmitter settle back to its wait state before next write.
        if (r_gap_cnt == c_gap_last) begin
          w_state = S_IDLE;
        end else begin
          w_gap_cnt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= 3'd0;
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
      r_ack         <= '0;
      r_tx_data     <= 8'h00;
      r_tx_wr       <= 1'b0;
      r_tx_en       <= 1'b0;
      r_baud        <= 3'b000;
      r_grant_id    <= 3'd0;
      r_frame_done  <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_rr_ptr      <= w_rr_ptr;
      r_to_cnt      <= w_to_cnt;
      r_gap_cnt     <= w_gap_cnt;
      r_ack         <= w_ack;
      r_tx_data     <= w_tx_data;
      r_tx_wr       <= w_tx_wr;
      r_tx_en       <= w_tx_en;
      r_baud        <= w_baud;
      r_grant_id    <= w_grant_id;
      r_frame_done  <= w_frame_done;
      r_err_timeout <= w_err_timeout;
    end
  end

  assign bus.req_ack     = r_ack;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_wr       = r_tx_wr;
  assign bus.tx_en       = r_tx_en;
  assign bus.baud_select = r_baud;
  assign o_grant_id      = r_grant_id;
  assign o_frame_done    = r_frame_done;
  assign o_err_timeout   = r_err_timeout;

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one `uart_transmitter` among `N_REQ` byte requesters. It owns the transmitter's control inputs (`Tx_DATA`, `Tx_WR`, `Tx_EN`, `baud_select`) and sequences exactly one frame at a time by tracking `Tx_BUSY`. It also holds baud configuration stable during frames and flags a transmitter that never starts. It sits between the system-side byte sources and the UART TX datapath, in the `clk` domain.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TO_W`, 20: width of the start-timeout counter.
- `TIMEOUT`, 20'hFFFFF: maximum cycles `tx_wr` may stay high waiting for `tx_busy`.
- `GAP_CYCLES`, 2: idle `clk` cycles enforced between frames, minimum 1.
- `clk` in 1: system clock, the same clock that feeds the transmitter's baud controller.
- `reset` in 1: reset, asynchronous, active-high.
- `cfg_enable` in 1: scheduler and transmitter enable.
- `cfg_baud` in 3: requested baud select.
- `req_valid` in N_REQ: requester i has a byte pending.
- `req_data` in 8*N_REQ: byte for requester i is at bits [8i+7:8i].
- `req_ack` out N_REQ: one-cycle pulse when requester i's byte is captured.
- `tx_data` out 8: to `Tx_DATA`.
- `tx_wr` out 1: to `Tx_WR`.
- `tx_en` out 1: to `Tx_EN`.
- `baud_select` out 3: to `baud_select`.
- `tx_busy` in 1: from `Tx_BUSY`.
- `grant_id` out 3: index of the last or current granted requester.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `err_timeout` out 1: one-cycle pulse when the transmitter failed to start.

## Operation
- `tx_busy` passes through a 2-flop synchronizer, giving `busy_s`.
- The FSM has states IDLE, WRITE, BUSY and GAP. It resets to IDLE.
- **IDLE**
  - `baud_select` <= `cfg_baud` every cycle.
  - `tx_en` <= `cfg_enable`.
  - If `cfg_enable` & |`req_valid`:
    - Choose g as the first valid index at or after `rr_ptr`, wrapping modulo N_REQ.
    - `tx_data` <= `req_data[g]`; `grant_id` <= g; `req_ack[g]` <= 1 for one cycle; `tx_wr` <= 1; timeout counter <= 0.
    - `rr_ptr` <= (g+1) mod N_REQ.
    - Go to WRITE.
- **WRITE**
  - `tx_wr` stays 1 and the counter increments.
  - If `busy_s`=1: `tx_wr` <= 0, go to BUSY.
  - Else if counter = TIMEOUT-1: `tx_wr` <= 0, `err_timeout` pulses, go to GAP. The captured byte is dropped and not retried.
- **BUSY**
  - Wait for `busy_s`=0.
  - Then `frame_done` pulses, the gap counter is cleared, and the FSM goes to GAP.
- **GAP**
  - Count GAP_CYCLES cycles, then go to IDLE.
  - This guarantees the transmitter is back in its WAIT state before the next `tx_wr`.
- **Configuration changes**
  - `baud_select` changes only in IDLE. A `cfg_baud` change during a frame takes effect at the first IDLE cycle after the frame.
  - `cfg_enable` deassertion mid-frame: `tx_en` stays 1 until the FSM returns to IDLE, and the current frame completes. In IDLE, `tx_en` <= 0 and no new grants are issued.
- **Requester rules**
  - A requester must hold `req_valid` and its data stable until it sees `req_ack`.
  - It may deassert `req_valid` in the cycle after the ack.
  - The scheduler ignores `req_valid` outside IDLE.
- `req_valid` deasserted before capture: no grant and no ack. This is legal.
- Reset mid-frame: all outputs return to their reset values immediately. The transmitter is reset by the same `reset`.

## Timing
- Reset values:
  - `req_ack`, `tx_wr`, `frame_done`, `err_timeout`, `tx_en`: 0.
  - `tx_data`: 8'h00.
  - `baud_select`: 3'b000.
  - `grant_id`: 0.
  - `rr_ptr`: 0.
  - Synchronizer flops: 0.
- Capture latency: `req_valid` high in IDLE at edge k gives `req_ack`, `tx_wr` and `tx_data` valid after edge k.
- `tx_wr` deasserts 3 edges after `Tx_BUSY` rises: 2 synchronizer edges plus 1 registered.
- `frame_done` pulses 3 edges after `Tx_BUSY` falls.
- The next grant happens no earlier than GAP_CYCLES+1 edges after `frame_done`.
- All outputs are registered.
- `req_ack` is one-hot or zero. `frame_done` and `err_timeout` are never high together.

## Test plan
- Single requester: `cfg_enable`=1, `cfg_baud`=3'b111, `req_valid`=4'b0001 with byte 8'hA5.
  - Expect `req_ack`=4'b0001 for 1 cycle, then `tx_wr` high until `busy_s`.
  - `TxD` carries start, bits 1,0,1,0,0,1,0,1 LSB first, parity 0, stop.
  - `frame_done` pulses once.
- Round robin: all 4 valid and held, bytes 8'h10, 8'h11, 8'h12, 8'h13.
  - Expect grant order 0,1,2,3,0.
  - With only requesters 1 and 3 valid after a grant to 1, the next grant is 3.
- Baud hold: change `cfg_baud` 3'b111→3'b110 mid-frame.
  - Expect `baud_select` stays 3'b111 until the first IDLE cycle after `frame_done`, then 3'b110.
- Timeout: TIMEOUT=16 with `tx_busy` tied 0.
  - Expect `tx_wr` high for 16 cycles, one `err_timeout` pulse, no `frame_done`, return to IDLE after the gap.
- Disable mid-frame: drop `cfg_enable` during D3.
  - Expect `tx_en` stays 1 until `frame_done` and the gap, then 0.
  - No further `req_ack` while `req_valid` stays asserted.
- Reset mid-frame: assert `reset` during the PARITY bit.
  - Expect all outputs at reset values asynchronously.
  - After release, the first grant goes to requester 0.
